// File: rtl/result_uart_streamer.sv
// result_uart_streamer
// Drains the output memory to the UART transmitter after a start pulse.
// Each address holds LANES 16-bit words; they leave as 2*LANES bytes,
// lane 0 first, low byte before high byte. One byte is in flight at a
// time: tx_en launches it, tx_done from the UART releases the next one.
module result_uart_streamer #(
  parameter int unsigned WORD_COUNT = 8192,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [LANES*16-1:0]   mem_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           bytes_sent
);

  localparam int unsigned BYTES_PER_ADDR = 2 * LANES;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_ADDR);
  localparam int unsigned LINE_W         = LANES * 16;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_ADDR - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic [7:0]        txd_q,   txd_d;
  logic [31:0]       cnt_q,   cnt_d;

  logic [IDX_W-1:0]  sel_idx;
  logic [7:0]        sel_byte;

  // Pick the byte that the next SEND will present: byte 0 when a fresh
  // line has just been latched, otherwise the byte after the current one.
  always_comb begin
    sel_idx  = '0;
    sel_byte = '0;
    if (state_q == S_WAIT_TX) begin
      sel_idx = idx_q + 1'b1;
    end
    for (int unsigned i = 0; i < BYTES_PER_ADDR; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_byte = line_q[8*i +: 8];
      end
    end
  end

  // Transfer sequencer: one memory read per address, then one byte per
  // UART handshake until the line is exhausted.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    line_d  = line_q;
    txd_d   = txd_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          addr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      S_READ: begin
        state_d = S_WAIT;
      end

      // Read data is only guaranteed in the cycle after the strobe, so the
      // line buffer is loaded on the WAIT->LATCH edge; LATCH then has a
      // stable line from which to preload byte 0.
      S_WAIT: begin
        line_d  = mem_rd_data;
        state_d = S_LATCH;
      end

      S_LATCH: begin
        idx_d   = '0;
        txd_d   = sel_byte;
        state_d = S_SEND;
      end

      S_SEND: begin
        state_d = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (tx_done) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            txd_d   = sel_byte;
            state_d = S_SEND;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      txd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_rd_en  = (state_q == S_READ);
  assign mem_addr   = addr_q;
  assign tx_data    = txd_q;
  assign tx_en      = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done       = (state_q == S_FINISH);
  assign bytes_sent = cnt_q;

endmodule

// File: tb/tb_result_uart_streamer.sv
// Testbench for result_uart_streamer: memory and UART models around the
// DUT, expected byte streams built from the lane/byte ordering rule.
module tb_result_uart_streamer;

  localparam int WC    = 3;
  localparam int LANES = 4;
  localparam int AW    = 16;
  localparam int BPA   = 2 * LANES;
  localparam int TOTAL = BPA * WC;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_addr;
  logic [LANES*16-1:0] mem_rd_data;
  logic [7:0]          tx_data;
  logic                tx_en;
  logic                tx_done;
  logic                busy;
  logic                done;
  logic [31:0]         bytes_sent;

  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  assign tx_done = uart_done | spur_done;

  result_uart_streamer #(
    .WORD_COUNT(WC),
    .LANES     (LANES),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_done    (tx_done),
    .busy       (busy),
    .done       (done),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory contents as lane words
  logic [15:0] mem [WC][LANES];
  logic [7:0]  exp_q[$];

  // observation records
  int          cyc = 0;
  logic [7:0]  txq[$];
  int          txcyc[$];
  int          rdcyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          unstable = 0;
  int          bad_addr = 0;
  int          rsp_delay = 10;
  int          stall_at = -1;
  int          rsp_cnt = 0;
  logic        pend = 1'b0;
  logic [7:0]  held = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // registered-read memory; output holds until the next read
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) begin
      if (int'(mem_addr) < WC) begin
        for (int k = 0; k < LANES; k++)
          mem_rd_data[16*k +: 16] <= mem[int'(mem_addr)][k];
      end else begin
        bad_addr <= bad_addr + 1;
      end
    end
  end

  // UART model and recorder
  always @(negedge clk) begin
    if (tx_en === 1'b1)
      rsp_cnt <= (txq.size() + 1 == stall_at) ? 500 : rsp_delay;
    else if (rsp_cnt > 0)
      rsp_cnt <= rsp_cnt - 1;
    uart_done <= (tx_en !== 1'b1) && (rsp_cnt == 1);

    if (rst && pend && tx_en !== 1'b1 && tx_data !== held)
      unstable <= unstable + 1;
    if (!rst) pend <= 1'b0;
    else if (tx_en === 1'b1) begin
      pend <= 1'b1;
      held <= tx_data;
    end else if (uart_done) pend <= 1'b0;

    if (tx_en === 1'b1) begin
      txq.push_back(tx_data);
      txcyc.push_back(cyc);
    end
    if (mem_rd_en === 1'b1) rdcyc.push_back(cyc);
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem_random();
    for (int a = 0; a < WC; a++)
      for (int k = 0; k < LANES; k++)
        mem[a][k] = 16'($urandom);
  endtask

  // reference stream: addresses in order, lane 0 first, low byte first
  task automatic build_expected();
    logic [15:0] w;
    exp_q.delete();
    for (int a = 0; a < WC; a++)
      for (int lane = 0; lane < LANES; lane++) begin
        w = mem[a][lane];
        exp_q.push_back(w % 256);
        exp_q.push_back(w / 256);
      end
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, expected 0", mem_rd_en); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", mem_addr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b, expected 0", tx_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL reset_bytes_sent: got %0d, expected 0", bytes_sent); end
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_basic_stream();
    int b, d0, s;
    bit ok;
    mem[0] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    mem[1] = '{16'h1211, 16'h1413, 16'h1615, 16'h1817};
    for (int k = 0; k < LANES; k++) mem[2][k] = 16'($urandom);
    build_expected();
    rsp_delay = 10;
    tick();
    b = txq.size(); d0 = done_cnt;
    pulse_start(s);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b, expected 1", busy); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: done not seen, expected within 2000 cycles"); end
    tick(); tick(); tick();
    checks++;
    if (txq.size() - b != TOTAL) begin
      errors++; $display("FAIL basic_count: got %0d bytes, expected %0d", txq.size() - b, TOTAL);
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        checks++;
        if (txq[b+i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %h, expected %h", i, txq[b+i], exp_q[i]); end
      end
    end
    checks++; if (bytes_sent !== 32'(TOTAL)) begin errors++; $display("FAIL basic_bytes_sent: got %0d, expected %0d", bytes_sent, TOTAL); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b, expected 0", busy); end
    checks++; if (int'(mem_addr) != WC - 1) begin errors++; $display("FAIL basic_last_addr: got %0d, expected %0d", mem_addr, WC - 1); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL basic_addr_range: got %0d bad reads, expected 0", bad_addr); end
  endtask

  task automatic test_latency();
    int b, r, s, d, gap;
    bit ok;
    d = int'($urandom_range(1, 6));
    rsp_delay = d;
    load_mem_random();
    build_expected();
    tick();
    b = txq.size(); r = rdcyc.size();
    pulse_start(s);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lat_timeout: done not seen, expected within 2000 cycles"); end
    tick(); tick(); tick();
    checks++;
    if (txq.size() - b != TOTAL || rdcyc.size() - r != WC) begin
      errors++; $display("FAIL lat_counts: got %0d bytes %0d reads, expected %0d bytes %0d reads",
                         txq.size() - b, rdcyc.size() - r, TOTAL, WC);
    end else begin
      checks++; if (rdcyc[r] != s + 1) begin errors++; $display("FAIL lat_first_read: got cycle %0d, expected %0d", rdcyc[r], s + 1); end
      checks++; if (txcyc[b] != s + 4) begin errors++; $display("FAIL lat_first_tx: got cycle %0d, expected %0d", txcyc[b], s + 4); end
      for (int i = 1; i < TOTAL; i++) begin
        gap = (i % BPA == 0) ? d + 4 : d + 1;
        checks++;
        if (txcyc[b+i] - txcyc[b+i-1] != gap) begin errors++; $display("FAIL lat_gap[%0d]: got %0d, expected %0d", i, txcyc[b+i] - txcyc[b+i-1], gap); end
      end
      for (int a = 1; a < WC; a++) begin
        checks++;
        if (rdcyc[r+a] != txcyc[b+a*BPA-1] + d + 1) begin errors++; $display("FAIL lat_read[%0d]: got cycle %0d, expected %0d", a, rdcyc[r+a], txcyc[b+a*BPA-1] + d + 1); end
      end
      checks++; if (done_cyc != txcyc[b+TOTAL-1] + d + 1) begin errors++; $display("FAIL lat_done: got cycle %0d, expected %0d", done_cyc, txcyc[b+TOTAL-1] + d + 1); end
    end
  endtask

  task automatic test_spurious();
    int b, d0, s, since_rd;
    bit ok;
    rsp_delay = 6;
    load_mem_random();
    build_expected();
    tick();
    b = txq.size(); d0 = done_cnt;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || txq.size() != b) begin errors++; $display("FAIL spur_idle: got busy %b tx %0d, expected busy 0 tx 0", busy, txq.size() - b); end
    pulse_start(s);
    since_rd = 99;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      since_rd++;
      if (mem_rd_en === 1'b1) begin spur_done = 1'b1; since_rd = 0; end
      else if (since_rd == 2) spur_done = 1'b1;
      if (busy === 1'b1 && (i % 9) == 4) start = 1'b1;
      tick();
      spur_done = 1'b0;
      start = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL spur_timeout: done not seen, expected within 3000 cycles"); end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (txq.size() - b != TOTAL) begin
      errors++; $display("FAIL spur_count: got %0d bytes, expected %0d", txq.size() - b, TOTAL);
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        checks++;
        if (txq[b+i] !== exp_q[i]) begin errors++; $display("FAIL spur_byte[%0d]: got %h, expected %h", i, txq[b+i], exp_q[i]); end
      end
    end
    checks++; if (bytes_sent !== 32'(TOTAL)) begin errors++; $display("FAIL spur_bytes_sent: got %0d, expected %0d", bytes_sent, TOTAL); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL spur_done_pulses: got %0d, expected 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_back_pressure();
    int b, u0, s, k, gap;
    bit ok;
    rsp_delay = 2;
    k = int'($urandom_range(1, TOTAL - 2));
    load_mem_random();
    build_expected();
    tick();
    b = txq.size(); u0 = unstable;
    stall_at = b + k + 1;
    pulse_start(s);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (txq.size() - b == k + 1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_reach_stall: byte %0d not launched, expected within 500 cycles", k); end
    for (int i = 0; i < 200; i++) tick();
    checks++; if (bytes_sent !== 32'(k)) begin errors++; $display("FAIL bp_mid_bytes_sent: got %0d, expected %0d", bytes_sent, k); end
    checks++; if (tx_data !== exp_q[k]) begin errors++; $display("FAIL bp_mid_tx_data: got %h, expected %h", tx_data, exp_q[k]); end
    checks++; if (txq.size() - b != k + 1) begin errors++; $display("FAIL bp_mid_tx_count: got %0d, expected %0d", txq.size() - b, k + 1); end
    wait_done(2000, ok);
    stall_at = -1;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen, expected within 2000 cycles"); end
    tick(); tick();
    checks++; if (unstable - u0 != 0) begin errors++; $display("FAIL bp_stable: got %0d tx_data changes, expected 0", unstable - u0); end
    checks++;
    if (txq.size() - b != TOTAL) begin
      errors++; $display("FAIL bp_count: got %0d bytes, expected %0d", txq.size() - b, TOTAL);
    end else begin
      gap = (((k + 1) % BPA) == 0) ? 504 : 501;
      checks++;
      if (txcyc[b+k+1] - txcyc[b+k] != gap) begin errors++; $display("FAIL bp_gap: got %0d, expected %0d", txcyc[b+k+1] - txcyc[b+k], gap); end
      for (int i = 0; i < TOTAL; i++) begin
        checks++;
        if (txq[b+i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h, expected %h", i, txq[b+i], exp_q[i]); end
      end
    end
    checks++; if (bytes_sent !== 32'(TOTAL)) begin errors++; $display("FAIL bp_bytes_sent: got %0d, expected %0d", bytes_sent, TOTAL); end
  endtask

  task automatic test_reset_mid();
    int b, s;
    bit ok;
    rsp_delay = 4;
    load_mem_random();
    build_expected();
    tick();
    b = txq.size();
    pulse_start(s);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (txq.size() - b == 5 && tx_en === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_reach: byte 5 not launched, expected within 500 cycles"); end
    rst = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rmid_tx_en: got %b, expected 0", tx_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
    checks++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL rmid_bytes_sent: got %0d, expected 0", bytes_sent); end
    checks++; if (mem_addr !== '0 || tx_data !== 8'h00) begin errors++; $display("FAIL rmid_addr_data: got %0d/%h, expected 0/00", mem_addr, tx_data); end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bytes_sent !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_stale_done: got count %0d busy %b, expected 0 0", bytes_sent, busy); end
    checks++; if (txq.size() - b != 5) begin errors++; $display("FAIL rmid_no_tx: got %0d bytes, expected 5", txq.size() - b); end
    b = txq.size();
    pulse_start(s);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: done not seen, expected within 2000 cycles"); end
    tick(); tick();
    checks++;
    if (txq.size() - b != TOTAL) begin
      errors++; $display("FAIL rmid_count: got %0d bytes, expected %0d", txq.size() - b, TOTAL);
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        checks++;
        if (txq[b+i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte[%0d]: got %h, expected %h", i, txq[b+i], exp_q[i]); end
      end
    end
    checks++; if (bytes_sent !== 32'(TOTAL)) begin errors++; $display("FAIL rmid_bytes_sent: got %0d, expected %0d", bytes_sent, TOTAL); end
  endtask

  task automatic test_back_to_back();
    int b, d0, s;
    bit ok;
    rsp_delay = int'($urandom_range(1, 3));
    load_mem_random();
    tick();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: done not seen, expected within 2000 cycles"); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL b2b_finish_start: got busy %b rd %b, expected 0 0", busy, mem_rd_en); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || mem_rd_en !== 1'b1) begin errors++; $display("FAIL b2b_idle_start: got busy %b rd %b, expected 1 1", busy, mem_rd_en); end
    checks++; if (bytes_sent !== 32'd0) begin errors++; $display("FAIL b2b_count_clear: got %0d, expected 0", bytes_sent); end
    load_mem_random();
    build_expected();
    b = txq.size();
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: done not seen, expected within 2000 cycles"); end
    tick(); tick();
    checks++;
    if (txq.size() - b != TOTAL) begin
      errors++; $display("FAIL b2b_count: got %0d bytes, expected %0d", txq.size() - b, TOTAL);
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        checks++;
        if (txq[b+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h, expected %h", i, txq[b+i], exp_q[i]); end
      end
    end
    checks++; if (bytes_sent !== 32'(TOTAL)) begin errors++; $display("FAIL b2b_bytes_sent: got %0d, expected %0d", bytes_sent, TOTAL); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d, expected 2", done_cnt - d0); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL b2b_addr_range: got %0d bad reads, expected 0", bad_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_latency();
    test_spurious();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
